adder14_sched: RTL and testbench
================================

# adder14_sched

Issue controller for the 8-input, 14-bit pipelined adder tree (`adder14sr`) that produces 12-bit DCT output samples.
- Accepts one row of eight signed 14-bit terms per handshake and launches it into the adder.
- Tracks each row through the fixed-latency, non-stallable adder pipeline, tagged with its row index.
- Collects the results into an output FIFO. Credit accounting guarantees the FIFO never overflows under downstream back-pressure.
- Sits between the row-product generator and the transpose/output stage.

## Interface
Parameters:
- `ADD_LAT`, 6, number of register stages in the adder from its term-input edge to a registered `dct`.
- `FIFO_DEPTH`, 8, output FIFO entries; must be ≥ 2.
- `ROWS`, 8, rows per block; row index width is clog2(`ROWS`).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: row available.
- `in_ready` out 1: row accepted this cycle when high with `in_valid`.
- `in_terms` in 112: eight 14-bit two's-complement terms; term i at [14i+13:14i].
- `flush` in 1: single-cycle request to stop accepting rows and drain.
- `add_terms` out 112: registered terms driven to the adder `n0`..`n7`.
- `add_dct` in 12: adder `dct` output.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: consumer pops when high with `out_valid`.
- `out_dct` out 12: result at the FIFO head.
- `out_idx` out clog2(`ROWS`): row index of the head result.
- `out_last` out 1: head is row `ROWS`-1 of a block.
- `busy` out 1: state is not IDLE.
- `flush_done` out 1: one-cycle pulse when a drain completes.

## Operation
- fire = `in_valid` & `in_ready`.
- On fire, `add_terms` loads `in_terms`. On every non-fire cycle, `add_terms` loads zero.
- A valid bit and its row tag (`issue_idx`) enter a shift register of length `ADD_LAT`+1.
- `issue_idx` increments mod `ROWS` on each fire.
- When the valid bit reaches the last shift-register stage, {`add_dct`, tag} is written to the FIFO. `out_last` = (tag == `ROWS`-1).
- `add_dct` is passed through unmodified; scaling and rounding belong to the adder.
- inflight = number of set valid bits in the shift register (held as a counter).
- credits = `FIFO_DEPTH` − fifo_count − inflight.
- `in_ready` = (state ≠ DRAIN) & (credits > 0). It is computed combinationally from registered state only.
- A FIFO push and pop in the same cycle are both performed; the count is unchanged. A pop from the full FIFO frees one credit in the next cycle.
- State machine:
  - IDLE → ACTIVE on fire.
  - ACTIVE → IDLE when `issue_idx`==0 and inflight==0 and the FIFO is empty.
  - IDLE or ACTIVE → DRAIN when `flush` is sampled high. A fire in that same cycle is accepted.
  - DRAIN → IDLE when inflight==0 and the FIFO is empty. On that transition `flush_done` pulses for one cycle and `issue_idx` is cleared to 0.
- Partial-block flush: rows already issued are still delivered; `out_last` is not generated for the truncated block.
- `flush` while in DRAIN is ignored.

## Timing
- Fire at edge k: `add_terms` is valid after edge k; the adder samples it at edge k+1; `add_dct` is valid after edge k+`ADD_LAT`; the FIFO write occurs at edge k+`ADD_LAT`+1.
- `out_valid` is high after edge k+7 at default parameters. Minimum latency is 7 cycles.
- Throughput: one row per cycle, sustained, while `out_ready` is held high.
- Reset values:
  - `in_ready`=1, `out_valid`=0, `busy`=0, `flush_done`=0.
  - `add_terms`=0, `out_dct`=0, `out_idx`=0, `out_last`=0.
  - All counters and the valid shift register are cleared.
- Reset mid-operation discards all in-flight and buffered rows immediately. Results that later emerge from the adder are ignored because the valid bits are cleared.

## Structure
- Package `adder14_pkg`:
  - Constants `TERM_W`=14, `DCT_W`=12, `NTERMS`=8, `ADD_LAT`=6.
  - The state enum {IDLE, ACTIVE, DRAIN}.
  - A result struct {dct, idx, last}.
- One sub-module, `adder14_sched_fifo`: synchronous FIFO of the result struct with full, empty and count outputs, supporting push and pop in the same cycle.
- The adder is instantiated outside this block.

## Test plan
- Single row, all terms 14'd8, `out_ready`=1 → `out_valid` rises exactly 7 cycles after fire; `out_dct`=12'd8, `out_idx`=0, `out_last`=0.
- Single row, all terms 14'h3FF8 (−8) → `out_dct`=12'hFF8.
- Eight back-to-back rows with term value equal to 8·r for row r, `out_ready`=1 → eight consecutive outputs with `out_dct`=8r, `out_idx`=0..7, and `out_last` high only on index 7; `busy` returns to 0.
- `out_ready`=0 with continuous `in_valid`:
  - Exactly 8 fires occur, then `in_ready`=0.
  - No FIFO overflow occurs.
  - One pop → `in_ready`=1 in the next cycle.
  - Data order is preserved.
- `flush` after 3 of 8 rows → 3 results delivered, with no `out_last`. `flush_done` pulses once after the FIFO empties. The next block starts at `out_idx` 0.
- Assert `rst_n` with 4 rows in flight → all outputs at reset values. No spurious `out_valid` appears within 10 cycles after reset is released.

Source files
------------

// File: rtl/adder14_pkg.sv
// rtl/adder14_pkg.sv - shared constants, FSM states and result record for the adder issue controller
package adder14_pkg;

    localparam int TERM_W    = 14;
    localparam int DCT_W     = 12;
    localparam int NTERMS    = 8;
    localparam int ADD_LAT   = 6;
    // Row tag width carried in the result record; sized for the 8-row DCT block.
    localparam int ROW_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN
    } state_e;

    typedef struct packed {
        logic [DCT_W-1:0]     dct;
        logic [ROW_IDX_W-1:0] idx;
        logic                 last;
    } result_t;

endpackage

// File: rtl/adder14_sched_fifo.sv
// rtl/adder14_sched_fifo.sv - synchronous result FIFO with simultaneous push/pop
module adder14_sched_fifo
    import adder14_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  result_t                    wdata_i,
    input  logic                       pop_i,
    output result_t                    rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    result_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only legal when a pop frees the slot in the same cycle.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && (!full_o || do_pop);

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Storage, wrapping pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/adder14_sched.sv
// rtl/adder14_sched.sv - issue controller tracking rows through the fixed-latency adder tree
module adder14_sched #(
    parameter int ADD_LAT    = adder14_pkg::ADD_LAT,
    parameter int FIFO_DEPTH = 8,
    parameter int ROWS       = 8
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic                                               in_valid,
    output logic                                               in_ready,
    input  logic [adder14_pkg::NTERMS*adder14_pkg::TERM_W-1:0] in_terms,
    input  logic                                               flush,
    output logic [adder14_pkg::NTERMS*adder14_pkg::TERM_W-1:0] add_terms,
    input  logic [adder14_pkg::DCT_W-1:0]                      add_dct,
    output logic                                               out_valid,
    input  logic                                               out_ready,
    output logic [adder14_pkg::DCT_W-1:0]                      out_dct,
    output logic [$clog2(ROWS)-1:0]                            out_idx,
    output logic                                               out_last,
    output logic                                               busy,
    output logic                                               flush_done
);

    import adder14_pkg::*;

    localparam int IDX_W   = $clog2(ROWS);
    localparam int TERMS_W = NTERMS * TERM_W;
    localparam int IF_W    = $clog2(ADD_LAT+2);
    localparam int CNT_W   = $clog2(FIFO_DEPTH+1);
    localparam int USE_W   = $clog2(FIFO_DEPTH+ADD_LAT+2) + 1;

    state_e             state_q, state_d;
    logic [TERMS_W-1:0] add_terms_q;
    logic [ADD_LAT:0]   vld_q;
    logic [IDX_W-1:0]   tag_q [ADD_LAT+1];
    logic [IDX_W-1:0]   issue_idx_q, issue_idx_d;
    logic [IF_W-1:0]    inflight_q;
    logic               flush_done_q;
    logic               fire;
    logic               push;
    logic               pop;
    logic               drain_done;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [USE_W-1:0]   used;
    result_t            wr_res;
    result_t            head;

    // Every launched row owns a FIFO slot from issue until pop, so the adder never
    // produces a result with nowhere to go.
    assign used       = USE_W'(fifo_count) + USE_W'(inflight_q);
    assign in_ready   = (state_q != DRAIN) && !fifo_full && (used < USE_W'(FIFO_DEPTH));
    assign fire       = in_valid && in_ready;
    assign push       = vld_q[ADD_LAT];
    assign pop        = out_valid && out_ready;
    assign drain_done = (inflight_q == '0) && fifo_empty;

    assign wr_res.dct  = add_dct;
    assign wr_res.idx  = ROW_IDX_W'(tag_q[ADD_LAT]);
    assign wr_res.last = (tag_q[ADD_LAT] == IDX_W'(ROWS-1));

    assign add_terms  = add_terms_q;
    assign out_valid  = !fifo_empty;
    assign out_dct    = head.dct;
    assign out_idx    = IDX_W'(head.idx);
    assign out_last   = head.last;
    assign busy       = (state_q != IDLE);
    assign flush_done = flush_done_q;

    // Next state and row-index bookkeeping; flush wins over the ACTIVE->IDLE exit.
    always_comb begin
        state_d     = state_q;
        issue_idx_d = issue_idx_q;
        if (fire) begin
            issue_idx_d = (issue_idx_q == IDX_W'(ROWS-1)) ? '0 : issue_idx_q + IDX_W'(1);
        end
        case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = DRAIN;
                end else if (fire) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (flush) begin
                    state_d = DRAIN;
                end else if ((issue_idx_q == '0) && drain_done) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_d     = IDLE;
                    issue_idx_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, launch register, in-flight count and drain-complete pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            issue_idx_q  <= '0;
            add_terms_q  <= '0;
            inflight_q   <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            issue_idx_q  <= issue_idx_d;
            add_terms_q  <= fire ? in_terms : '0;
            flush_done_q <= (state_q == DRAIN) && drain_done;
            case ({fire, push})
                2'b10:   inflight_q <= inflight_q + IF_W'(1);
                2'b01:   inflight_q <= inflight_q - IF_W'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    // Valid/tag shift register mirroring the adder pipeline depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i <= ADD_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            vld_q    <= {vld_q[ADD_LAT-1:0], fire};
            tag_q[0] <= issue_idx_q;
            for (int i = 1; i <= ADD_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    adder14_sched_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (wr_res),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_adder14_sched.sv
// tb/tb_adder14_sched.sv - directed self-checking bench for adder14_sched
module tb_adder14_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [111:0] in_terms;
    logic         flush;
    logic [111:0] add_terms;
    logic [11:0]  add_dct;
    logic         out_valid;
    logic         out_ready;
    logic [11:0]  out_dct;
    logic [2:0]   out_idx;
    logic         out_last;
    logic         busy;
    logic         flush_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adder14_sched #(
        .ADD_LAT    (6),
        .FIFO_DEPTH (8),
        .ROWS       (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_terms   (in_terms),
        .flush      (flush),
        .add_terms  (add_terms),
        .add_dct    (add_dct),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_dct    (out_dct),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .busy       (busy),
        .flush_done (flush_done)
    );

    // Adder tree model: mean of eight signed terms, six register stages, no reset.
    logic [11:0] add_pipe [6];
    always @(posedge clk) begin
        logic signed [16:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            s = s + {{3{add_terms[14*i+13]}}, add_terms[14*i +: 14]};
        end
        add_pipe[0] <= 12'(s >>> 3);
        for (int i = 1; i < 6; i++) begin
            add_pipe[i] <= add_pipe[i-1];
        end
    end
    assign add_dct = add_pipe[5];

    function automatic logic [111:0] mk_row(input int v);
        logic [111:0] r;
        for (int i = 0; i < 8; i++) begin
            r[14*i +: 14] = 14'(v);
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int got;
        int fires;
        int pulses;
        int lasts;
        int spurious;

        rst_n = 1'b0; in_valid = 1'b0; in_terms = '0; flush = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        // Reset state
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_add_terms", (add_terms === '0), 1);
        chk("rst_out_dct", out_dct, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_last", out_last, 0);
        rst_n = 1'b1;
        tick;

        // Single row of +8: latency and pass-through
        out_ready = 1'b1;
        in_valid = 1'b1; in_terms = mk_row(8);
        chk("a_in_ready", in_ready, 1);
        tick;
        in_valid = 1'b0;
        chk("a_add_terms", (add_terms === mk_row(8)), 1);
        chk("a_busy", busy, 1);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin tick; n++; end
        chk("a_latency", n, 7);
        chk("a_dct", out_dct, 12'd8);
        chk("a_idx", out_idx, 0);
        chk("a_last", out_last, 0);
        tick;
        chk("a_add_terms_zero", (add_terms === '0), 1);

        // Single row of -8
        in_valid = 1'b1; in_terms = mk_row(14'h3FF8);
        tick;
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin tick; n++; end
        chk("b_latency", n, 7);
        chk("b_dct", out_dct, 12'hFF8);
        chk("b_idx", out_idx, 1);
        tick;

        // Flush with nothing outstanding: DRAIN for one cycle then done pulse
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("f0_busy", busy, 1);
        chk("f0_in_ready", in_ready, 0);
        chk("f0_done_early", flush_done, 0);
        tick;
        chk("f0_done", flush_done, 1);
        chk("f0_idle", busy, 0);
        tick;
        chk("f0_done_pulse", flush_done, 0);

        // Eight back-to-back rows, value 8r
        got = 0;
        for (int c = 0; c < 30; c++) begin
            if (out_valid === 1'b1) begin
                chk("c_dct", out_dct, 8 * got);
                chk("c_idx", out_idx, got);
                chk("c_last", out_last, (got == 7));
                got++;
            end
            in_valid = (c < 8);
            in_terms = mk_row(8 * c);
            if (c < 8) chk("c_in_ready", in_ready, 1);
            tick;
        end
        in_valid = 1'b0;
        chk("c_count", got, 8);
        chk("c_busy", busy, 0);

        // Back-pressure: exactly eight fires, then credits exhausted
        out_ready = 1'b0;
        fires = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1;
            in_terms = mk_row(8 * fires);
            if (in_ready === 1'b1) fires++;
            tick;
        end
        in_valid = 1'b0;
        chk("d_fires", fires, 8);
        chk("d_in_ready_low", in_ready, 0);
        chk("d_out_valid", out_valid, 1);
        chk("d_head_dct", out_dct, 0);
        chk("d_head_idx", out_idx, 0);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("d_credit_back", in_ready, 1);
        out_ready = 1'b1;
        for (int r = 1; r < 8; r++) begin
            chk("d_order_valid", out_valid, 1);
            chk("d_order_dct", out_dct, 8 * r);
            chk("d_order_idx", out_idx, r);
            chk("d_order_last", out_last, (r == 7));
            tick;
        end
        chk("d_empty", out_valid, 0);
        tick;
        chk("d_busy", busy, 0);

        // Partial block: three rows then flush
        for (int r = 0; r < 3; r++) begin
            in_valid = 1'b1;
            in_terms = mk_row(8 * (r + 1));
            tick;
        end
        in_valid = 1'b0;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("e_drain_busy", busy, 1);
        chk("e_drain_in_ready", in_ready, 0);
        got = 0; pulses = 0; lasts = 0;
        for (int c = 0; c < 30; c++) begin
            if (out_valid === 1'b1) begin
                chk("e_dct", out_dct, 8 * (got + 1));
                chk("e_idx", out_idx, got);
                if (out_last === 1'b1) lasts++;
                got++;
            end
            if (flush_done === 1'b1) begin
                pulses++;
                chk("e_done_results", got, 3);
                chk("e_done_empty", out_valid, 0);
            end
            tick;
        end
        chk("e_count", got, 3);
        chk("e_pulses", pulses, 1);
        chk("e_no_last", lasts, 0);
        in_valid = 1'b1; in_terms = mk_row(40);
        tick;
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin tick; n++; end
        chk("e_next_latency", n, 7);
        chk("e_next_idx", out_idx, 0);
        chk("e_next_dct", out_dct, 12'd40);
        tick;

        // Reset with four rows in flight
        for (int r = 0; r < 4; r++) begin
            in_valid = 1'b1;
            in_terms = mk_row(8 * (r + 2));
            tick;
        end
        in_valid = 1'b0;
        chk("g_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("g_in_ready", in_ready, 1);
        chk("g_out_valid", out_valid, 0);
        chk("g_busy", busy, 0);
        chk("g_flush_done", flush_done, 0);
        chk("g_add_terms", (add_terms === '0), 1);
        chk("g_out_dct", out_dct, 0);
        chk("g_out_idx", out_idx, 0);
        chk("g_out_last", out_last, 0);
        tick;
        tick;
        rst_n = 1'b1;
        spurious = 0;
        for (int c = 0; c < 10; c++) begin
            tick;
            if (out_valid !== 1'b0) spurious++;
        end
        chk("g_no_spurious", spurious, 0);
        chk("g_idle_after", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
